// File: rtl/gpio_in_capture.sv
// GPIO input front end: pin synchronizer, masked change detect and a show-ahead snapshot FIFO.
// Optional per-entry cycle timestamp on `ts` when GPIO_CAP_TIMESTAMP_EN is defined.
module gpio_in_capture #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         gpio_pins,
  input  logic                     cap_en,
  input  logic [WIDTH-1:0]         mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH)-1:0] out_addr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef GPIO_CAP_TIMESTAMP_EN
  ,
  output logic [15:0]              ts
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ARM_N = SYNC_STAGES + 1;
  localparam int ARM_W = $clog2(ARM_N + 1);
  localparam logic [AW:0]       FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(ARM_N);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_p;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic             chg;
  logic             push_req;
  logic             push_acc;
  logic             pop;
  logic             full;
  logic [AW-1:0]    slot;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [AW-1:0]    addr_mem [DEPTH];

  // Synchronizer stages and the one-cycle-delayed copy used for change detect
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      prev_p <= '0;
    end else begin
      sync_p[0] <= gpio_pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_p <= sync;
    end
  end

  assign sync = sync_p[SYNC_STAGES-1];

  // Captures stay suppressed until the synchronizer and prev have flushed reset zeros
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  assign armed    = (arm_cnt == ARM_DONE);
  assign chg      = |((sync ^ prev_p) & mask);
  assign push_req = armed & cap_en & chg;
  assign full     = (level == FULL_LVL);
  assign pop      = out_valid & out_ready;
  assign push_acc = push_req & (~full | pop);

  // FIFO control
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      slot   <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
        slot   <= slot + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      // A fresh overflow outranks a clear in the same cycle
      if (push_req & full & ~pop) ovf <= 1'b1;
      else if (ovf_clr)           ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      data_mem[wr_ptr] <= sync;
      addr_mem[wr_ptr] <= slot;
    end
  end

  assign out_valid = (level != '0);
  assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
  assign out_addr  = out_valid ? addr_mem[rd_ptr] : '0;

`ifdef GPIO_CAP_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] ts_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (push_acc) ts_mem[wr_ptr] <= ts_cnt;
  end

  assign ts = out_valid ? ts_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_gpio_in_capture.sv
// Directed + randomized bench for gpio_in_capture against a queue-based reference model.
module tb_gpio_in_capture;

  localparam int W = 32;
  localparam int D = 4;
  localparam int S = 2;

  logic          clk;
  logic          reset;
  logic [W-1:0]  gpio_pins;
  logic          cap_en;
  logic [W-1:0]  mask;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_addr;
  logic [2:0]    level;
  logic          ovf;
  logic          ovf_clr;
`ifdef GPIO_CAP_TIMESTAMP_EN
  logic [15:0]   ts;
`endif

  gpio_in_capture #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .gpio_pins (gpio_pins),
    .cap_en    (cap_en),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .level     (level),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef GPIO_CAP_TIMESTAMP_EN
    ,
    .ts        (ts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pins reach sync S edges after sampling; FIFO is a queue of snapshots
  typedef struct {
    logic [W-1:0] d;
    int           a;
    int           t;
  } ent_t;

  ent_t         mq[$];
  logic [W-1:0] pin_q[$];
  logic [W-1:0] m_sync, m_prev;
  int           m_cyc, m_slot, m_ts;
  logic         m_ovf;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pin_q.delete();
    repeat (S) pin_q.push_back('0);
    m_sync = '0;
    m_prev = '0;
    m_cyc  = 0;
    m_slot = 0;
    m_ts   = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge();
    bit   do_pop, do_req, is_full, chg;
    ent_t e;
    if (reset) begin
      model_reset();
      return;
    end
    do_pop  = (mq.size() != 0) && out_ready;
    chg     = |((m_sync ^ m_prev) & mask);
    do_req  = (m_cyc >= S + 1) && cap_en && chg;
    is_full = (mq.size() == D);
    if (do_pop) void'(mq.pop_front());
    if (do_req && (!is_full || do_pop)) begin
      e.d = m_sync;
      e.a = m_slot;
      e.t = m_ts;
      mq.push_back(e);
      m_slot = (m_slot + 1) % D;
    end
    if (do_req && is_full && !do_pop) m_ovf = 1'b1;
    else if (ovf_clr)                 m_ovf = 1'b0;
    m_prev = m_sync;
    pin_q.push_back(gpio_pins);
    void'(pin_q.pop_front());
    m_sync = pin_q[0];
    if (m_cyc < 1000) m_cyc++;
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic check_model();
    bit empty;
    empty = (mq.size() == 0);
    chk("valid", W'(out_valid), W'(!empty));
    chk("level", W'(level), W'(mq.size()));
    chk("ovf", W'(ovf), W'(m_ovf));
    chk("data", out_data, empty ? '0 : mq[0].d);
    chk("addr", W'(out_addr), empty ? '0 : W'(mq[0].a));
`ifdef GPIO_CAP_TIMESTAMP_EN
    chk("ts", W'(ts), empty ? '0 : W'(mq[0].t));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset(input logic [W-1:0] pins, input int n);
    reset     = 1'b1;
    gpio_pins = pins;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  int exp_d[4] = '{2, 3, 4, 6};
  int exp_a[4] = '{1, 2, 3, 0};

  initial begin
    model_reset();
    reset = 1'b1; gpio_pins = '1; cap_en = 1'b1; mask = '1;
    out_ready = 1'b0; ovf_clr = 1'b0;

    // Reset/arm with pins high through reset
    do_reset('1, 3);
    chk("rst_level", W'(level), 0);
    chk("rst_valid", W'(out_valid), 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("arm_valid", W'(out_valid), 0);
      chk("arm_level", W'(level), 0);
    end

    // Basic capture: 0 -> A5 seen three edges later
    do_reset('0, 2);
    repeat (6) cycle();
    gpio_pins = 32'h0000_00A5;
    cycle(); chk("cap_e0", W'(out_valid), 0);
    cycle(); chk("cap_e1", W'(out_valid), 0);
    cycle(); chk("cap_e2", W'(out_valid), 1);
    chk("cap_data", out_data, 32'h0000_00A5);
    chk("cap_addr", W'(out_addr), 0);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    chk("cap_pop_level", W'(level), 0);

    // Mask: unwatched bit 20 does not push, watched bit 3 does and carries bit 20
    mask = 32'h0000_FFFF;
    gpio_pins = gpio_pins ^ 32'h0010_0000;
    repeat (5) cycle();
    chk("mask_nopush", W'(level), 0);
    gpio_pins = gpio_pins ^ 32'h0000_0008;
    repeat (3) cycle();
    chk("mask_level", W'(level), 1);
    chk("mask_data", out_data, 32'h0010_00AD);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;

    // Fill and overflow
    do_reset('0, 2);
    mask = '1;
    repeat (6) cycle();
    for (int v = 1; v <= 5; v++) begin
      gpio_pins = W'(v);
      repeat (2) cycle();
    end
    repeat (2) cycle();
    chk("fill_level", W'(level), 4);
    chk("fill_ovf", W'(ovf), 1);
    chk("fill_head", out_data, 1);
    chk("fill_addr", W'(out_addr), 0);
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    chk("ovf_clr", W'(ovf), 0);

    // Full with simultaneous push and pop
    gpio_pins = 32'h6;
    repeat (2) cycle();
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    chk("pp_level", W'(level), 4);
    chk("pp_ovf", W'(ovf), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", out_data, W'(exp_d[i]));
      chk("drain_addr", W'(out_addr), W'(exp_a[i]));
      out_ready = 1'b1; cycle();
    end
    out_ready = 1'b0;
    chk("drain_level", W'(level), 0);

    // Reset mid-stream
    gpio_pins = 32'h7; repeat (2) cycle();
    gpio_pins = 32'h8; repeat (3) cycle();
    chk("mid_level", W'(level), 2);
    do_reset(32'h8, 1);
    chk("mid_rst_level", W'(level), 0);
    chk("mid_rst_valid", W'(out_valid), 0);
    chk("mid_rst_ovf", W'(ovf), 0);
    repeat (6) cycle();
    gpio_pins = 32'h9; repeat (3) cycle();
    chk("mid_addr", W'(out_addr), 0);
    chk("mid_data", out_data, 32'h9);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 30) gpio_pins = $urandom;
      if ($urandom_range(0, 99) < 5)  mask = ($urandom_range(0, 1) != 0) ? '1 : W'($urandom);
      cap_en    = ($urandom_range(0, 99) < 90);
      out_ready = ($urandom_range(0, 99) < 40);
      ovf_clr   = ($urandom_range(0, 99) < 10);
      reset     = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_in_capture.md
# gpio_in_capture

Input-side front end for the Fast GPIO bank. Synchronizes the external GPIO pins into `clk`, detects masked pin changes, and buffers each changed snapshot in a small FIFO. The FIFO drains over a valid/ready handshake into the `gpio_in` register group. Each snapshot carries a wrap-around slot index that selects the target `gpio_in` register (0..N-1).

## Interface
Parameters:
- `WIDTH`, 32, pin/snapshot width
- `DEPTH`, 4, FIFO entries (power of two, ≥2); also the slot-index modulus, matching the 4 `gpio_in` registers
- `SYNC_STAGES`, 2, synchronizer flops (≥2)

Ports:
- `clk`  in  1  single system clock
- `reset`  in  1  synchronous, active-high reset
- `gpio_pins`  in  WIDTH  asynchronous external pins
- `cap_en`  in  1  capture enable
- `mask`  in  WIDTH  per-bit change-detect enable (1 = watched)
- `out_valid`  out  1  FIFO head holds a snapshot
- `out_ready`  in  1  consumer accepts head this cycle
- `out_data`  out  WIDTH  head snapshot
- `out_addr`  out  $clog2(DEPTH)  head slot index
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy
- `ovf`  out  1  sticky overflow flag
- `ovf_clr`  in  1  clears `ovf`
- `ts`  out  16  head timestamp (only with `GPIO_CAP_TIMESTAMP_EN`)

## Operation
- Synchronizer: `SYNC_STAGES` flops per bit. `sync` is the last stage. `prev` registers `sync` every cycle.
- Change detect: `chg = |((sync ^ prev) & mask)`.
- Arm counter: after `reset` deasserts, captures are suppressed for `SYNC_STAGES+1` cycles while the pipeline fills. After that, `armed` = 1 until the next reset.
- Push condition: `armed & cap_en & chg`. The pushed entry is {`sync`, `slot`}. `slot` is a `$clog2(DEPTH)`-bit counter that increments on every accepted push and wraps DEPTH-1 → 0.
- Pop: happens when `out_valid & out_ready`.
- FIFO is show-ahead: `out_data`/`out_addr` always present the head entry. `out_valid = (level != 0)`.
- Full (`level == DEPTH`):
  - A push with no simultaneous pop is dropped. `ovf` is set, and `slot` does not advance.
  - A push with a simultaneous pop is accepted and `level` stays DEPTH.
- Empty: `out_valid` = 0 and `out_ready` is ignored. A simultaneous push on empty is accepted; `out_valid` rises the next cycle. There is no same-cycle bypass.
- `ovf` stays set until `ovf_clr`. If `ovf_clr` and a new overflow occur in the same cycle, set wins.
- `cap_en` = 0 blocks pushes only. `prev` keeps tracking, so no change is replayed when `cap_en` reasserts. Draining continues.
- Reset values: synchronizer, `prev`, `slot`, pointers, `level`, `ovf`, arm counter, `out_valid`, `out_data`, `out_addr` (and `ts`) are all 0.
- Reset mid-operation: FIFO contents are discarded, all state above returns to its reset value, and re-arm is required.

## Timing
- A pin edge stable before clock edge E0 appears on `sync` after edge E(SYNC_STAGES-1). It is pushed at the next edge. `out_valid` is high after edge E(SYNC_STAGES), i.e. 3 edges for the default parameters.
- Throughput: 1 push and 1 pop per cycle.
- A pin glitch shorter than one clock may be missed. This is allowed.
- `level` updates on the edge of the push/pop. The net change is +1, −1, or 0 (push and pop together).

## Configuration
- `GPIO_CAP_TIMESTAMP_EN` defined:
  - A free-running 16-bit cycle counter runs from the cycle after reset; it is 0 during reset and wraps at 0xFFFF.
  - Its value at push is stored with each entry and presented on `ts` with the head.
- Not defined: no counter, no timestamp storage, no `ts` port.

## Test plan
- Reset/arm: hold `gpio_pins`=0xFFFFFFFF through reset, release, `cap_en`=1, `mask`=all ones. Required: no push, `out_valid`=0, `level`=0 for 10 cycles.
- Basic capture: after arm, `gpio_pins` 0x0 → 0x0000_00A5. Required: `out_valid` rises 3 edges later with `out_data`=0x000000A5, `out_addr`=0. Pop with `out_ready`=1 → `level`=0.
- Mask: `mask`=0x0000_FFFF, toggle bit 20 only → no push. Then toggle bit 3 → one push with bit 20's current value included in `out_data`.
- Fill/overflow, `out_ready`=0:
  - 5 distinct changes (0x1, 0x2, 0x3, 0x4, 0x5) → `level`=4, `ovf`=1, and heads pop in order 0x1..0x4 with `out_addr` 0,1,2,3.
  - `ovf_clr` → `ovf`=0.
- Full with simultaneous push+pop: FIFO full, `out_ready`=1 while a change arrives. Required: `level` stays 4, `ovf` stays 0, new entry has `out_addr`=0 (wrap).
- Reset mid-stream: 2 entries queued, assert `reset` for 1 cycle → `level`=0, `out_valid`=0, `ovf`=0, next capture has `out_addr`=0 (and `ts` restarted when `GPIO_CAP_TIMESTAMP_EN`).
